// File: rtl/cnt_share_arbiter.sv
// Round-robin owner of a shared 4-bit up/down counter: grants one N-step run at a
// time, drives the counter enables, stops at the counter limits and reports the result.
module cnt_share_arbiter #(
    parameter int          LEN_W   = 4,
    parameter logic [3:0]  CNT_MAX = 4'd15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [3:0]       cnt_val,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             sat,
    output logic [LEN_W-1:0] steps,
    output logic             up_cnt_en,
    output logic             down_cnt_en,
    output logic             busy,
    output logic             owner
);

    // state | meaning
    // IDLE  | waiting for a request; gnt is combinational here
    // RUN   | one enable per cycle until rem runs out or a limit is reached
    // DONE  | one-cycle done pulse for the owner; round-robin pointer advances
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             r_owner;
    logic             r_dir;
    logic             r_sat;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_steps;

    logic w_any;
    logic w_win;
    logic w_limit;
    logic w_en;
    logic w_rem_zero;

    always_comb begin
        w_any      = req0 | req1;
        // only one requester: it wins; both: the pointer decides
        w_win      = (req0 && req1) ? r_ptr : req1;
        w_limit    = r_dir ? (cnt_val == CNT_MAX) : (cnt_val == 4'd0);
        w_rem_zero = (r_rem == '0);
        w_en       = (r_state == RUN) && !w_rem_zero && !w_limit;

        gnt0        = (r_state == IDLE) && w_any && !w_win;
        gnt1        = (r_state == IDLE) && w_any &&  w_win;
        // reset gates the enables so an aborted run stops the counter immediately
        up_cnt_en   = rst && w_en &&  r_dir;
        down_cnt_en = rst && w_en && !r_dir;
        done0       = (r_state == DONE) && !r_owner;
        done1       = (r_state == DONE) &&  r_owner;
        busy        = (r_state != IDLE);
        owner       = r_owner;
        steps       = r_steps;
        sat         = r_sat;

        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_any) w_state_nxt = RUN;
            RUN: begin
                if (w_rem_zero || w_limit || ((r_rem == LEN_W'(1)) && w_en))
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_dir   <= 1'b0;
            r_sat   <= 1'b0;
            r_rem   <= '0;
            r_steps <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_dir   <= w_win ? dir1 : dir0;
                        r_rem   <= w_win ? len1 : len0;
                        r_steps <= '0;
                        r_sat   <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_en) begin
                        r_rem   <= r_rem - LEN_W'(1);
                        r_steps <= r_steps + LEN_W'(1);
                    end
                    if (w_limit && !w_rem_zero)
                        r_sat <= 1'b1;
                end
                DONE:    r_ptr <= ~r_owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_share_arbiter.sv
// Directed bench for cnt_share_arbiter with a behavioural 4-bit counter in the loop.
module tb_cnt_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0;
    logic [3:0] len0 = 4'd0, len1 = 4'd0;
    logic [3:0] cnt_val = 4'd0;
    logic       gnt0, gnt1, done0, done1, sat, up_cnt_en, down_cnt_en, busy, owner;
    logic [3:0] steps;
    logic       ld = 1'b0;
    logic [3:0] ld_val = 4'd0;
    int         total = 0;
    int         bad = 0;

    cnt_share_arbiter #(.LEN_W(4), .CNT_MAX(4'd15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
        .len0(len0), .len1(len1), .cnt_val(cnt_val),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .sat(sat), .steps(steps), .up_cnt_en(up_cnt_en), .down_cnt_en(down_cnt_en),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // the shared counter, preloadable from the bench
    always @(posedge clk) begin
        if (ld)               cnt_val <= ld_val;
        else if (up_cnt_en)   cnt_val <= cnt_val + 4'd1;
        else if (down_cnt_en) cnt_val <= cnt_val - 4'd1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        ld = 1'b1; ld_val = v;
        step();
        ld = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_steps", steps, 0);
        chk("rst_sat", sat, 0);
        chk("rst_up", up_cnt_en, 0);
        rst = 1'b1;
        load(4'd0);

        // up run of 5 from 0
        req0 = 1; dir0 = 1; len0 = 4'd5; #1;
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        step(); req0 = 0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t1_up", up_cnt_en, 1);
            chk("t1_dn", down_cnt_en, 0);
            step();
        end
        chk("t1_done0", done0, 1);
        chk("t1_steps", steps, 5);
        chk("t1_sat", sat, 0);
        chk("t1_cnt", cnt_val, 5);
        chk("t1_up_off", up_cnt_en, 0);
        step();
        chk("t1_done0_low", done0, 0);
        chk("t1_steps_hold", steps, 5);

        // round robin with both requesting
        do_reset();
        req0 = 1; req1 = 1; dir0 = 1; dir1 = 1; len0 = 4'd1; len1 = 4'd1; #1;
        chk("rr_gnt0_a", gnt0, 1);
        chk("rr_gnt1_a", gnt1, 0);
        step(); step();
        chk("rr_done0", done0, 1);
        step();
        chk("rr_gnt1_b", gnt1, 1);
        chk("rr_gnt0_b", gnt0, 0);
        step(); step();
        chk("rr_done1", done1, 1);
        chk("rr_owner1", owner, 1);
        step();
        chk("rr_gnt0_c", gnt0, 1);
        chk("rr_gnt1_c", gnt1, 0);
        step(); req0 = 0; req1 = 0; #1;
        step(); step();
        chk("rr_idle", busy, 0);

        // up saturation from 13
        load(4'd13);
        req0 = 1; dir0 = 1; len0 = 4'd6; #1;
        chk("sat_up_gnt0", gnt0, 1);
        step(); req0 = 0; #1;
        chk("sat_up_en1", up_cnt_en, 1);
        step();
        chk("sat_up_en2", up_cnt_en, 1);
        step();
        chk("sat_up_lim_en", up_cnt_en, 0);
        chk("sat_up_lim_cnt", cnt_val, 15);
        step();
        chk("sat_up_done", done0, 1);
        chk("sat_up_steps", steps, 2);
        chk("sat_up_sat", sat, 1);
        step();
        chk("sat_up_nowrap", cnt_val, 15);

        // down saturation from 1
        load(4'd1);
        req1 = 1; dir1 = 0; len1 = 4'd4; #1;
        chk("sat_dn_gnt1", gnt1, 1);
        step(); req1 = 0; #1;
        chk("sat_dn_en", down_cnt_en, 1);
        step();
        chk("sat_dn_lim_en", down_cnt_en, 0);
        step();
        chk("sat_dn_done1", done1, 1);
        chk("sat_dn_steps", steps, 1);
        chk("sat_dn_sat", sat, 1);
        chk("sat_dn_cnt", cnt_val, 0);
        step();

        // zero-length run
        req0 = 1; dir0 = 1; len0 = 4'd0; #1;
        chk("len0_gnt0", gnt0, 1);
        step(); req0 = 0; #1;
        chk("len0_busy", busy, 1);
        chk("len0_no_up", up_cnt_en, 0);
        chk("len0_no_done", done0, 0);
        step();
        chk("len0_done", done0, 1);
        chk("len0_steps", steps, 0);
        chk("len0_sat", sat, 0);
        chk("len0_cnt", cnt_val, 0);
        step();

        // reset during the third RUN cycle of a len=8 run
        req0 = 1; dir0 = 1; len0 = 4'd8; #1;
        chk("abort_gnt0", gnt0, 1);
        step();
        step();
        step();
        chk("abort_en_before", up_cnt_en, 1);
        rst = 0; #1;
        chk("abort_en_drop", up_cnt_en, 0);
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", done0, 0);
        chk("abort_steps", steps, 0);
        chk("abort_owner", owner, 0);
        chk("abort_cnt", cnt_val, 2);
        rst = 1; #1;
        chk("abort_regnt", gnt0, 1);
        step(); len0 = 4'd3; req0 = 0; #1;
        chk("abort_new_run_en", up_cnt_en, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
